// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-memory path.
//   MEMOP_*     : memop field encodings (also used by the controller decode)
//   mau_state_t : mem_access_unit FSM states
//   mau_illegal : accept-time legality check (alignment, opcode, store width)
package mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [2:0] {
        MAU_IDLE = 3'd0,
        MAU_RD   = 3'd1,
        MAU_WAIT = 3'd2,
        MAU_WR   = 3'd3,
        MAU_RESP = 3'd4
    } mau_state_t;

    // Unsigned sub-word ops exist only for loads; misaligned h/w are rejected.
    function automatic logic mau_illegal(input logic we, input logic [2:0] memop,
                                         input logic [1:0] lane);
        case (memop)
            MEMOP_B:  return 1'b0;
            MEMOP_H:  return lane[0];
            MEMOP_W:  return lane != 2'b00;
            MEMOP_BU: return we;
            MEMOP_HU: return we | lane[0];
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// lane_align: combinational byte/half lane steering for a 32-bit word RAM.
//   word      in  32 : word read from RAM
//   wdata     in  32 : store data (low byte/half used for sub-word stores)
//   lane      in  2  : byte address bits [1:0]
//   memop     in  3  : access size/sign encoding
//   load_val  out 32 : extracted and extended load value
//   store_word out 32: word with only the addressed byte/half replaced
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  memop,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (lane)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];

        load_val = word;
        case (memop)
            MEMOP_B:  load_val = {{24{byte_v[7]}}, byte_v};
            MEMOP_H:  load_val = {{16{half_v[15]}}, half_v};
            MEMOP_BU: load_val = {24'd0, byte_v};
            MEMOP_HU: load_val = {16'd0, half_v};
            default:  load_val = word;
        endcase

        store_word = word;
        case (memop)
            MEMOP_B: begin
                case (lane)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            MEMOP_H: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer for a word-wide RAM without byte enables.
//   clk, rst_n           : clock, async active-low reset
//   req/we/memop/addr/wdata : request, sampled only in IDLE
//   busy, done, err, rdata  : CPU-side status/result (done is a 1-cycle pulse)
//   mem_addr/mem_rd_en/mem_wr_en/mem_wdata/mem_rdata : RAM port
// Sub-word stores are read-modify-write; word stores write directly.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_AW = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        memop,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] LAST = 2'(RD_LAT - 1);

    mau_state_t  state;
    logic        we_q;
    logic        err_q;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [1:0]  cnt;
    logic [31:0] load_val;
    logic [31:0] store_word;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:MEM_AW+2];

    // mem_wdata doubles as the store-data holding register until the merge
    // result replaces it at the capture edge.
    lane_align u_align (
        .word       (mem_rdata),
        .wdata      (mem_wdata),
        .lane       (lane_q),
        .memop      (op_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MAU_IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            op_q      <= MEMOP_B;
            lane_q    <= 2'd0;
            cnt       <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
        end else begin
            case (state)
                MAU_IDLE: if (req) begin
                    we_q      <= we;
                    op_q      <= memop;
                    lane_q    <= addr[1:0];
                    mem_addr  <= addr[MEM_AW+1:2];
                    mem_wdata <= wdata;
                    cnt       <= 2'd0;
                    if (mau_illegal(we, memop, addr[1:0])) begin
                        err_q <= 1'b1;
                        state <= MAU_RESP;
                    end else begin
                        err_q <= 1'b0;
                        state <= (we && memop == MEMOP_W) ? MAU_WR : MAU_RD;
                    end
                end
                MAU_RD: state <= MAU_WAIT;
                MAU_WAIT: begin
                    if (cnt == LAST) begin
                        if (we_q) begin
                            mem_wdata <= store_word;
                            state     <= MAU_WR;
                        end else begin
                            rdata <= load_val;
                            state <= MAU_RESP;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                MAU_WR:   state <= MAU_RESP;
                MAU_RESP: state <= MAU_IDLE;
                default:  state <= MAU_IDLE;
            endcase
        end
    end

    assign busy      = (state != MAU_IDLE);
    assign done      = (state == MAU_RESP);
    assign err       = done & err_q;
    assign mem_rd_en = (state == MAU_RD);
    assign mem_wr_en = (state == MAU_WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit with RD_LAT=1 (dut1)
// and RD_LAT=3 (dut3), each attached to its own small RAM model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int AW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        req1 = 1'b0, req3 = 1'b0, rst_n1 = 1'b0, rst_n3 = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  memop = 3'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;

    logic          busy1, done1, err1, rd1, wr1;
    logic [31:0]   rdata1, mwd1, mrd1;
    logic [AW-1:0] ma1;
    logic          busy3, done3, err3, rd3, wr3;
    logic [31:0]   rdata3, mwd3, mrd3;
    logic [AW-1:0] ma3;

    mem_access_unit #(.MEM_AW(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .req(req1), .we(we), .memop(memop), .addr(addr),
        .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1), .err(err1),
        .mem_addr(ma1), .mem_rd_en(rd1), .mem_wr_en(wr1), .mem_wdata(mwd1), .mem_rdata(mrd1));

    mem_access_unit #(.MEM_AW(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .req(req3), .we(we), .memop(memop), .addr(addr),
        .wdata(wdata), .busy(busy3), .done(done3), .rdata(rdata3), .err(err3),
        .mem_addr(ma3), .mem_rd_en(rd3), .mem_wr_en(wr3), .mem_wdata(mwd3), .mem_rdata(mrd3));

    // RAM models: read data valid RD_LAT cycles after the rd strobe edge
    logic [31:0] ram1 [0:63];
    logic [31:0] ram3 [0:63];
    logic [31:0] rp1;
    logic [31:0] rp3 [0:2];
    logic        pre1 = 1'b0, pre3 = 1'b0;
    logic [5:0]  pre_a = 6'd0;
    logic [31:0] pre_d = 32'd0;
    int nrd1 = 0, nwr1 = 0, ndn1 = 0, nrd3 = 0, nwr3 = 0, ndn3 = 0;

    always @(posedge clk) begin
        rp1 <= ram1[ma1[5:0]];
        if (pre1)     ram1[pre_a] <= pre_d;
        else if (wr1) ram1[ma1[5:0]] <= mwd1;
        rp3[0] <= ram3[ma3[5:0]];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
        if (pre3)     ram3[pre_a] <= pre_d;
        else if (wr3) ram3[ma3[5:0]] <= mwd3;
        nrd1 <= nrd1 + int'(rd1); nwr1 <= nwr1 + int'(wr1); ndn1 <= ndn1 + int'(done1);
        nrd3 <= nrd3 + int'(rd3); nwr3 <= nwr3 + int'(wr3); ndn3 <= ndn3 + int'(done3);
    end
    assign mrd1 = rp1;
    assign mrd3 = rp3[2];

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input bit sel, input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_a = a; pre_d = d;
        if (sel) pre3 = 1'b1; else pre1 = 1'b1;
        @(negedge clk);
        pre1 = 1'b0; pre3 = 1'b0;
    endtask

    // One transaction; lat = edges after accept at which done is sampled high
    // (0 if it never arrives), wr_at = first edge at which a write strobe is seen.
    task automatic op(input bit sel, input logic w, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd_o, output logic er_o,
                      output int drd, output int dwr, output int wr_at);
        int rd0, wr0;
        @(negedge clk);
        we = w; memop = o; addr = a; wdata = d;
        if (sel) req3 = 1'b1; else req1 = 1'b1;
        rd0 = sel ? nrd3 : nrd1;
        wr0 = sel ? nwr3 : nwr1;
        lat = 0; wr_at = 0; rd_o = 32'd0; er_o = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0; req3 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (wr_at == 0 && (sel ? wr3 : wr1)) wr_at = k;
            if (sel ? done3 : done1) begin
                lat = k;
                rd_o = sel ? rdata3 : rdata1;
                er_o = sel ? err3 : err1;
                break;
            end
        end
        // strobes are tallied on the edge following this negedge
        @(posedge clk); #1;
        drd = (sel ? nrd3 : nrd1) - rd0;
        dwr = (sel ? nwr3 : nwr1) - wr0;
        @(negedge clk);
    endtask

    int lat, drd, dwr, wat;
    logic [31:0] rv;
    logic er;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_strb", {30'd0, rd1, wr1}, 32'd0);
        chk("rst_done_err", {30'd0, done1, err1}, 32'd0);
        chk("rst_rdata", rdata1, 32'd0);
        chk("rst_maddr", {17'd0, ma1}, 32'd0);
        chk("rst_mwdata", mwd1, 32'd0);
        rst_n1 = 1'b1; rst_n3 = 1'b1;

        preload(1'b0, 6'd4, 32'h8899AABB);

        // 1: lb
        op(1'b0, 1'b0, MEMOP_B, 32'h13, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("lb_lat", lat, 3); chk("lb_rdata", rv, 32'hFFFFFF88);
        chk("lb_err", {31'd0, er}, 32'd0); chk("lb_nrd", drd, 1); chk("lb_nwr", dwr, 0);

        // 2: lhu / lh / lbu / lw
        op(1'b0, 1'b0, MEMOP_HU, 32'h12, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("lhu_rdata", rv, 32'h00008899); chk("lhu_lat", lat, 3);
        op(1'b0, 1'b0, MEMOP_H, 32'h10, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("lh_rdata", rv, 32'hFFFFAABB);
        op(1'b0, 1'b0, MEMOP_BU, 32'h11, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("lbu_rdata", rv, 32'h000000AA);
        op(1'b0, 1'b0, MEMOP_W, 32'h10, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("lw_rdata", rv, 32'h8899AABB);

        // 3: sb RMW, then sh on the merged word
        op(1'b0, 1'b1, MEMOP_B, 32'h11, 32'h123456CC, lat, rv, er, drd, dwr, wat);
        chk("sb_lat", lat, 4); chk("sb_nrd", drd, 1); chk("sb_nwr", dwr, 1);
        chk("sb_ram", ram1[4], 32'h8899CCBB);
        chk("sb_rdata_hold", rv, 32'h8899AABB);
        op(1'b0, 1'b1, MEMOP_H, 32'h12, 32'hFFFF1234, lat, rv, er, drd, dwr, wat);
        chk("sh_lat", lat, 4); chk("sh_ram", ram1[4], 32'h1234CCBB);

        // 4: sw
        op(1'b0, 1'b1, MEMOP_W, 32'h20, 32'hDEADBEEF, lat, rv, er, drd, dwr, wat);
        chk("sw_lat", lat, 2); chk("sw_wr_at", wat, 1);
        chk("sw_nrd", drd, 0); chk("sw_nwr", dwr, 1); chk("sw_ram", ram1[8], 32'hDEADBEEF);

        // 5: errors
        op(1'b0, 1'b0, MEMOP_W, 32'h22, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("elw_lat", lat, 1); chk("elw_err", {31'd0, er}, 32'd1);
        chk("elw_strb", drd + dwr, 0); chk("elw_rdata", rv, 32'h8899AABB);
        op(1'b0, 1'b1, MEMOP_H, 32'h21, 32'h5555, lat, rv, er, drd, dwr, wat);
        chk("esh_lat", lat, 1); chk("esh_err", {31'd0, er}, 32'd1);
        chk("esh_strb", drd + dwr, 0); chk("esh_ram", ram1[8], 32'hDEADBEEF);
        op(1'b0, 1'b0, 3'b011, 32'h10, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("e011_lat", lat, 1); chk("e011_err", {31'd0, er}, 32'd1);
        chk("e011_strb", drd + dwr, 0); chk("e011_rdata", rv, 32'h8899AABB);
        op(1'b0, 1'b1, MEMOP_BU, 32'h10, 32'h77, lat, rv, er, drd, dwr, wat);
        chk("esbu_err", {31'd0, er}, 32'd1); chk("esbu_strb", drd + dwr, 0);
        op(1'b0, 1'b0, MEMOP_B, 32'h10, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("post_err_lb", rv, 32'hFFFFFFBB); chk("post_err_err", {31'd0, er}, 32'd0);

        // 6: RD_LAT=3 load, then reset during WAIT of an sb
        preload(1'b1, 6'd4, 32'h8899AABB);
        op(1'b1, 1'b0, MEMOP_W, 32'h10, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("l3_lat", lat, 5); chk("l3_rdata", rv, 32'h8899AABB); chk("l3_nrd", drd, 1);
        op(1'b1, 1'b1, MEMOP_B, 32'h12, 32'h0000_00EE, lat, rv, er, drd, dwr, wat);
        chk("sb3_lat", lat, 6); chk("sb3_ram", ram3[4], 32'h88EEAABB);

        begin
            int dn0, wr0;
            @(negedge clk);
            we = 1'b1; memop = MEMOP_B; addr = 32'h10; wdata = 32'h11;
            req3 = 1'b1;
            dn0 = ndn3; wr0 = nwr3;
            @(posedge clk);          // accept -> RD
            @(negedge clk); req3 = 1'b0;
            @(negedge clk);          // in WAIT
            rst_n3 = 1'b0;
            #1;
            chk("abort_busy", {31'd0, busy3}, 32'd0);
            chk("abort_strb", {30'd0, rd3, wr3}, 32'd0);
            @(negedge clk);
            rst_n3 = 1'b1;
            repeat (6) @(negedge clk);
            chk("abort_done", ndn3 - dn0, 0);
            chk("abort_nwr", nwr3 - wr0, 0);
            chk("abort_ram", ram3[4], 32'h88EEAABB);
        end
        op(1'b1, 1'b0, MEMOP_HU, 32'h12, 32'h0, lat, rv, er, drd, dwr, wat);
        chk("post_rst_lat", lat, 5); chk("post_rst_rdata", rv, 32'h000088EE);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
